// File: rtl/barrel_sched.sv
// barrel_sched: round-robin launch scheduler for the barrel pool with slot allocation and launch cooldown
// Ports: clk/rst_n (async active-low reset); game_en flushes state when low; animation blocks launches;
// req[1:0] launch requests (rising edge); done per-slot release edges; active per-slot draw enable;
// launch/launch_idx/grant describe an allocation; busy marks cooldown; free_cnt counts free slots.
module barrel_sched #(
  parameter int BARRELS  = 5,
  parameter int COOLDOWN = 162_500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_en,
  input  logic               animation,
  input  logic [1:0]         req,
  input  logic [BARRELS-1:0] done,
  output logic [BARRELS-1:0] active,
  output logic               launch,
  output logic [2:0]         launch_idx,
  output logic [1:0]         grant,
  output logic               busy,
  output logic [2:0]         free_cnt
);
  localparam int CW = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;
  typedef enum logic {ST_IDLE, ST_COOLDOWN} state_t;
  state_t             r_state, w_state_next;
  logic [BARRELS-1:0] r_active, r_done_prev, w_done_rise, w_alloc, w_active_next;
  logic [1:0]         r_pending, r_req_prev, r_grant, w_req_rise, w_grant, w_pending_next;
  logic [2:0]         r_launch_idx, r_free_cnt, w_slot, w_free_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic               r_launch, r_rr, w_win, w_go, w_cnt_last;
  always_comb begin
    w_req_rise  = req & ~r_req_prev;
    w_done_rise = done & ~r_done_prev;
    w_slot = '0;
    for (int i = BARRELS - 1; i >= 0; i--)
      if (!r_active[i]) w_slot = 3'(i);
    w_alloc = BARRELS'(1) << w_slot;
    w_win   = (r_pending == 2'b11) ? r_rr : r_pending[1];
    // allocation looks at active before this cycle's releases, so a freed slot waits one cycle
    w_go    = (r_state == ST_IDLE) && game_en && !animation && (r_pending != 2'b00) && (r_free_cnt != 3'd0);
    w_grant = w_go ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    w_active_next  = (r_active & ~w_done_rise) | (w_go ? w_alloc : '0);
    w_pending_next = (r_pending & ~w_grant) | w_req_rise;
    w_cnt_last   = r_cnt == CW'(COOLDOWN - 1);
    w_state_next = (r_state == ST_IDLE) ? (w_go ? ST_COOLDOWN : ST_IDLE) : (w_cnt_last ? ST_IDLE : ST_COOLDOWN);
    w_cnt_next   = (r_state == ST_COOLDOWN && !w_cnt_last) ? r_cnt + 1'b1 : '0;
    w_free_next  = '0;
    for (int i = 0; i < BARRELS; i++)
      w_free_next = w_free_next + {2'b00, ~w_active_next[i]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_active     <= '0;
      r_pending    <= '0;
      r_req_prev   <= '0;
      r_done_prev  <= '0;
      r_rr         <= 1'b0;
      r_cnt        <= '0;
      r_launch     <= 1'b0;
      r_launch_idx <= '0;
      r_grant      <= '0;
      r_free_cnt   <= 3'(BARRELS);
    end else begin
      r_req_prev  <= req;
      r_done_prev <= done;
      if (!game_en) begin
        r_state    <= ST_IDLE;
        r_active   <= '0;
        r_pending  <= '0;
        r_cnt      <= '0;
        r_launch   <= 1'b0;
        r_grant    <= '0;
        r_free_cnt <= 3'(BARRELS);
      end else begin
        r_state    <= w_state_next;
        r_active   <= w_active_next;
        r_pending  <= w_pending_next;
        r_cnt      <= w_cnt_next;
        r_launch   <= w_go;
        r_grant    <= w_grant;
        r_free_cnt <= w_free_next;
        if (w_go) begin
          r_launch_idx <= w_slot;
          r_rr         <= ~w_win;
        end
      end
    end
  end
  assign active     = r_active;
  assign launch     = r_launch;
  assign launch_idx = r_launch_idx;
  assign grant      = r_grant;
  assign busy       = r_state == ST_COOLDOWN;
  assign free_cnt   = r_free_cnt;
endmodule

// File: tb/tb_barrel_sched.sv
// tb_barrel_sched: directed stimulus with a cycle-level reference model for barrel_sched
module tb_barrel_sched;
  localparam int NB = 5;
  localparam int CD = 4;
  logic          clk, rst_n, game_en, animation;
  logic [1:0]    req;
  logic [NB-1:0] done;
  logic [NB-1:0] active;
  logic          launch, busy;
  logic [2:0]    launch_idx, free_cnt;
  logic [1:0]    grant;
  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 0;
  barrel_sched #(.BARRELS(NB), .COOLDOWN(CD)) dut (
    .clk(clk), .rst_n(rst_n), .game_en(game_en), .animation(animation), .req(req), .done(done),
    .active(active), .launch(launch), .launch_idx(launch_idx), .grant(grant), .busy(busy), .free_cnt(free_cnt)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // reference model: slot set, pending requests, and cycles of cooldown left
  logic [NB-1:0] m_active, m_pdone;
  logic [1:0]    m_pend, m_preq, m_grant;
  logic [2:0]    m_idx;
  logic          m_launch, m_rr;
  int            m_left;
  function automatic int lowest_free(logic [NB-1:0] a);
    for (int i = 0; i < NB; i++) if (!a[i]) return i;
    return 0;
  endfunction
  function automatic int zeros(logic [NB-1:0] a);
    int n = 0;
    for (int i = 0; i < NB; i++) if (!a[i]) n++;
    return n;
  endfunction
  function automatic int winner(logic [1:0] p, logic rr);
    return (p == 2'b11) ? int'(rr) : (p[1] ? 1 : 0);
  endfunction
  wire m_go = game_en && m_left == 0 && !animation && m_pend != 2'b00 && m_active != {NB{1'b1}};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= '0; m_pdone <= '0; m_pend <= '0; m_preq <= '0; m_grant <= '0;
      m_idx <= '0; m_launch <= 0; m_rr <= 0; m_left <= 0;
    end else begin
      m_preq  <= req;
      m_pdone <= done;
      if (!game_en) begin
        m_active <= '0; m_pend <= '0; m_left <= 0; m_launch <= 0; m_grant <= '0;
      end else begin
        m_active <= (m_active & ~(done & ~m_pdone)) | (m_go ? NB'(1) << lowest_free(m_active) : '0);
        m_pend   <= (m_pend & ~(m_go ? 2'(1) << winner(m_pend, m_rr) : 2'b00)) | (req & ~m_preq);
        m_left   <= m_go ? CD : (m_left > 0 ? m_left - 1 : 0);
        m_launch <= m_go;
        m_grant  <= m_go ? 2'(1) << winner(m_pend, m_rr) : 2'b00;
        if (m_go) begin
          m_idx <= 3'(lowest_free(m_active));
          m_rr  <= winner(m_pend, m_rr) == 0;
        end
      end
    end
  end
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("m_active", 8'(active), 8'(m_active));
    chk("m_launch", 8'(launch), 8'(m_launch));
    chk("m_idx", 8'(launch_idx), 8'(m_idx));
    chk("m_grant", 8'(grant), 8'(m_grant));
    chk("m_busy", 8'(busy), 8'(m_left > 0));
    chk("m_free", 8'(free_cnt), 8'(zeros(m_active)));
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic launch_lit(string tag, logic [2:0] idx, logic [1:0] g, logic [NB-1:0] act);
    chk({tag, "_launch"}, 8'(launch), 8'd1);
    chk({tag, "_idx"}, 8'(launch_idx), 8'(idx));
    chk({tag, "_grant"}, 8'(grant), 8'(g));
    chk({tag, "_active"}, 8'(active), 8'(act));
  endtask
  task automatic req_launch(logic [1:0] r);
    req = r; tick(); req = 2'b00; tick(5);
  endtask
  initial begin
    rst_n = 0; game_en = 0; animation = 0; req = 0; done = 0;
    tick(2);
    chk("rst_active", 8'(active), 8'd0);
    chk("rst_free", 8'(free_cnt), 8'd5);
    chk_en = 1;
    rst_n = 1; game_en = 1;
    tick();
    // single launch latency and cooldown length
    req = 2'b01; tick();
    chk("lat_early", 8'(launch), 8'd0);
    tick();
    launch_lit("lat", 3'd0, 2'b01, 5'b00001);
    chk("lat_busy0", 8'(busy), 8'd1);
    chk("lat_free", 8'(free_cnt), 8'd4);
    req = 2'b00;
    for (int k = 1; k <= 3; k++) begin tick(); chk("lat_busy", 8'(busy), 8'd1); end
    tick();
    chk("lat_busy_end", 8'(busy), 8'd0);
    // asynchronous reset in the middle of a cooldown
    req = 2'b01; tick(2);
    launch_lit("rc", 3'd1, 2'b01, 5'b00011);
    tick();
    rst_n = 0; #1;
    chk("rc_active", 8'(active), 8'd0);
    chk("rc_launch", 8'(launch), 8'd0);
    chk("rc_busy", 8'(busy), 8'd0);
    chk("rc_free", 8'(free_cnt), 8'd5);
    chk("rc_idx", 8'(launch_idx), 8'd0);
    req = 2'b00; tick(2);
    rst_n = 1; tick();
    // simultaneous requests served round-robin
    req = 2'b11; tick(); req = 2'b00; tick();
    launch_lit("rr1", 3'd0, 2'b01, 5'b00001);
    tick(5);
    launch_lit("rr2", 3'd1, 2'b10, 5'b00011);
    tick(4);
    req = 2'b11; tick(); req = 2'b00; tick();
    launch_lit("rr3", 3'd2, 2'b01, 5'b00111);
    tick(5);
    launch_lit("rr4", 3'd3, 2'b10, 5'b01111);
    tick(4);
    // pool full: request held until a slot is released
    req = 2'b01; tick(); req = 2'b00; tick();
    launch_lit("full", 3'd4, 2'b01, 5'b11111);
    chk("full_free", 8'(free_cnt), 8'd0);
    tick(4);
    req = 2'b10; tick(); req = 2'b00; tick(3);
    chk("full_hold", 8'(launch), 8'd0);
    done = 5'b00100; tick();
    chk("full_rel", 8'(active), 8'(5'b11011));
    chk("full_rel_l", 8'(launch), 8'd0);
    tick();
    launch_lit("full2", 3'd2, 2'b10, 5'b11111);
    // release of slot 1 in the same cycle slot 0 is allocated
    done = 5'b00000; tick();
    done = 5'b00001; tick();
    chk("sim_pre", 8'(active), 8'(5'b11110));
    done = 5'b00000; req = 2'b01; tick();
    req = 2'b00; tick();
    done = 5'b00010; tick();
    launch_lit("sim", 3'd0, 2'b01, 5'b11101);
    chk("sim_free", 8'(free_cnt), 8'd1);
    done = 5'b00000; tick();
    done = 5'b00010; tick();
    chk("inact_done", 8'(active), 8'(5'b11101));
    done = 5'b00000; tick(3);
    // animation blocks launching
    animation = 1; req = 2'b01; tick(4);
    chk("anim_block", 8'(launch), 8'd0);
    animation = 0; req = 2'b00; tick();
    launch_lit("anim", 3'd1, 2'b01, 5'b11111);
    tick(5);
    // game_en flush
    game_en = 0; tick();
    chk("flush0", 8'(active), 8'd0);
    game_en = 1; tick();
    req_launch(2'b01);
    req_launch(2'b10);
    req = 2'b01; tick(); req = 2'b00; tick();
    launch_lit("ge3", 3'd2, 2'b01, 5'b00111);
    req = 2'b01; tick(); req = 2'b00;
    game_en = 0; tick();
    chk("ge_active", 8'(active), 8'd0);
    chk("ge_free", 8'(free_cnt), 8'd5);
    chk("ge_busy", 8'(busy), 8'd0);
    game_en = 1; tick(6);
    chk("ge_pend_clr", 8'(launch), 8'd0);
    chk("ge_act_clr", 8'(active), 8'd0);
    game_en = 0; req = 2'b10; tick();
    game_en = 1; tick(3);
    chk("ge_discard", 8'(active), 8'd0);
    req = 2'b00; tick(2);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
